// File: rtl/axi4s_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_IN AXI4-Stream slave ports share
// one AXI4-Stream master port. A grant is held from the first beat of a
// packet until its tlast beat handshakes, so packets never interleave.
module axi4s_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 32,
  localparam int ID_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        s_tvalid,
  output logic [NUM_IN-1:0]        s_tready,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tid,
  output logic                     busy,
  output logic [15:0]              pkt_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] gnt, gnt_nxt;
  logic [ID_W-1:0] last, last_nxt;

  logic [ID_W-1:0] arb_base;
  logic [ID_W-1:0] arb_sel;
  logic            arb_found;
  logic            last_xfer;

  // Unpacked view of the flat slave data bus, one word per port.
  logic [DATA_W-1:0] s_data_arr [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign s_data_arr[g] = s_tdata[g*DATA_W +: DATA_W];
  end

  // While granted, the search starts after the current owner so a port
  // finishing a packet is the last candidate; in IDLE it starts after last.
  assign arb_base = (state == GRANT) ? gnt : last;

  // Round-robin pick: lowest valid index above arb_base wins, otherwise the
  // lowest valid index at or below it (wrap-around, ending at arb_base).
  always_comb begin
    // NOTE: every variable gets a default before any condition so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (s_tvalid[i] && (i <= int'(arb_base))) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(i);
      end
    end
    // Indices above the base take precedence, so this pass overrides.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (s_tvalid[i] && (i > int'(arb_base))) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(i);
      end
    end
  end

  // Output mux: the granted port drives the master side, everything else
  // (including all ports in IDLE) sees ready low and the output reads zero.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == GRANT) begin
      m_tvalid      = s_tvalid[gnt];
      m_tdata       = s_data_arr[gnt];
      m_tlast       = s_tlast[gnt];
      s_tready[gnt] = m_tready;
    end
  end

  assign last_xfer = m_tvalid && m_tready && m_tlast;
  assign m_tid     = gnt;
  assign busy      = (state == GRANT);

  // Next-state: take a grant from IDLE, or hand over on a tlast handshake.
  // Non-last beats never move the grant, even if the owner drops valid.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = GRANT;
          gnt_nxt   = arb_sel;
          last_nxt  = arb_sel;
        end
      end
      GRANT: begin
        if (last_xfer) begin
          // The finishing port is still valid on its own tlast beat, so it
          // wins the re-arbitration whenever no other port is requesting.
          if (arb_found) begin
            gnt_nxt  = arb_sel;
            last_nxt = arb_sel;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, round-robin pointer and packet counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= ID_W'(NUM_IN - 1);
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      if (last_xfer) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule
